fft_frame_source: RTL and testbench
===================================

# fft_frame_source

Frame source that drives the input side of the team's AXI-Stream FFT wrapper. It accepts a free-running stream of packed I/Q samples, buffers them in a small FIFO, and emits fixed-length frames on `do_en`/`do_last`/`dout`. It honours downstream backpressure through `do_ready`, which connects to the FFT core's `S_AXIS_DATA_tready`. It sits between the ADC/decimator stage and the FFT block, and supplies the `di_en`/`di_last`/`din` signals that the FFT block consumes.

## Interface
- `FRAME_LEN`, 1024: samples per frame; range 2..65535.
- `DATA_W`, 32: sample width, {Q[31:16], I[15:0]}, passed through unmodified.
- `FIFO_DEPTH`, 16: input FIFO entries; power of two, minimum 4.
- `GAP_CYCLES`, 0: forced idle cycles after each frame's last beat; 0 disables the gap.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_en`  in  1  input sample valid; no ready, source cannot stall.
- `s_data`  in  DATA_W  input sample.
- `do_ready`  in  1  downstream ready (FFT `S_AXIS_DATA_tready`).
- `do_en`  out  1  output valid (to FFT `di_en`).
- `do_last`  out  1  last beat of frame (to FFT `di_last`).
- `dout`  out  DATA_W  output sample (to FFT `din`).
- `frame_cnt`  out  16  completed frames, wraps at 65535→0.
- `overflow`  out  1  sticky: at least one input sample dropped since reset.

## Operation
- Push: when `s_en`=1 and FIFO count < FIFO_DEPTH, `s_data` is written on the edge.
  - When the FIFO is full, the sample is dropped and `overflow` is set, even if a pop happens in the same cycle.
- Output register: holds `dout`/`do_en`/`do_last`.
  - A handshake (beat) occurs when `do_en`=1 and `do_ready`=1.
  - The register loads from the FIFO head when the state permits, the FIFO is non-empty, and (`do_en`=0 or a beat occurs this cycle).
  - If a beat occurs and no load happens, `do_en` clears.
- `dout`, `do_last` and `do_en` must stay stable while `do_en`=1 and `do_ready`=0.
- Sample index: `idx` (0..FRAME_LEN-1) counts loads into the output register.
  - `do_last` is loaded as (`idx`==FRAME_LEN-1).
  - `idx` wraps to 0 after loading the last sample.
- FSM:
  - IDLE: the output register is empty. Go to SEND when the FIFO is non-empty; loading is allowed in that same cycle.
  - SEND: loading is allowed. After the beat with `do_last`=1:
    - go to GAP if GAP_CYCLES>0, with the gap counter set to GAP_CYCLES;
    - otherwise stay in SEND if the FIFO is non-empty, else go to IDLE.
  - GAP: no loads. Decrement the gap counter each cycle; at 1 go to IDLE. The FIFO keeps accepting input during GAP.
- `frame_cnt` increments on each beat with `do_last`=1.
- Reset (asserted at any time, including mid-frame):
  - FIFO emptied, `idx`=0, FSM to IDLE;
  - `do_en`=0, `do_last`=0, `dout`=0, `frame_cnt`=0, `overflow`=0.
  - A partial frame is discarded; the first sample after reset is index 0 of a new frame.

## Timing
- Latency: a sample pushed on edge E0 into an empty FIFO with an idle output stage gives `do_en`=1 after edge E1.
- With continuous input and `do_ready`=1 held, throughput is one beat per cycle, and `do_en` stays high across frame boundaries when GAP_CYCLES=0.
- With GAP_CYCLES=G>0, `do_en` is low for exactly G cycles between a frame's last beat and the next frame's first beat, provided data is waiting.
- `overflow` is set after the edge where the drop occurs.
- `frame_cnt` updates after the edge of the last beat.
- Total storage is FIFO_DEPTH+1: the FIFO plus the output register.

## Test plan
- Reset values: hold `rst_n`=0 with random `s_en` → `do_en`=0, `do_last`=0, `dout`=0, `frame_cnt`=0, `overflow`=0.
- Basic frame (FRAME_LEN=8, `do_ready`=1):
  - stimulus: push 0x0001..0x0008 on consecutive edges E0..E7;
  - response: `do_en` high after E1..E8 with matching `dout`, `do_last`=1 only with 0x0008, `frame_cnt`=1, `overflow`=0.
- Backpressure (FRAME_LEN=8):
  - stimulus: drop `do_ready` for 5 cycles while `dout`=0x0003;
  - response: `dout`/`do_en` held; the frame resumes in order with no loss; `do_last` is on 0x0008.
- Overflow (FIFO_DEPTH=4, `do_ready`=0):
  - stimulus: push 0xA0..0xA5 on 6 consecutive edges, then raise `do_ready`;
  - response: `overflow`=1 after the 6th edge; output is exactly 0xA0..0xA4; 0xA5 is lost.
- Gap (FRAME_LEN=4, GAP_CYCLES=3, continuous input, `do_ready`=1):
  - response: `do_en` low for exactly 3 cycles after each `do_last` beat; `frame_cnt` is 1 then 2.
- Reset mid-frame (FRAME_LEN=8):
  - stimulus: assert `rst_n`=0 after the 5th beat, release, then push 8 samples;
  - response: the new frame's 8th beat carries `do_last`=1 and `frame_cnt` becomes 1.

Source files
------------

// File: rtl/fft_frame_source_if.sv
// rtl/fft_frame_source_if.sv - sample input and framed output bundle for fft_frame_source
interface fft_frame_source_if #(
    parameter int DATA_W = 32
);
    logic              s_en;
    logic [DATA_W-1:0] s_data;
    logic              do_ready;
    logic              do_en;
    logic              do_last;
    logic [DATA_W-1:0] dout;
    logic [15:0]       frame_cnt;
    logic              overflow;

    // Upstream/downstream environment side: supplies samples and ready, observes frames
    modport master (
        output s_en,
        output s_data,
        output do_ready,
        input  do_en,
        input  do_last,
        input  dout,
        input  frame_cnt,
        input  overflow
    );

    // Frame source side
    modport slave (
        input  s_en,
        input  s_data,
        input  do_ready,
        output do_en,
        output do_last,
        output dout,
        output frame_cnt,
        output overflow
    );
endinterface

// File: rtl/fft_frame_source.sv
// rtl/fft_frame_source.sv - buffers free-running I/Q samples and emits fixed-length frames to the FFT
module fft_frame_source #(
    parameter int FRAME_LEN  = 1024,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    fft_frame_source_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_END   = GW'(1);
    localparam bit            HAS_GAP   = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Input FIFO storage; depth is a power of two so pointers wrap naturally
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              overflow_r;

    // Output register and framing state
    state_t            state;
    logic [GW-1:0]     gap_cnt;
    logic [IW-1:0]     idx;
    logic              do_en_r;
    logic              do_last_r;
    logic [DATA_W-1:0] dout_r;
    logic [15:0]       frame_cnt_r;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              beat;
    logic              last_beat;
    logic              load_ok;
    logic              load;
    logic [DATA_W-1:0] head;

    assign fifo_full  = (count == FIFO_FULL);
    assign fifo_empty = (count == '0);
    // A full FIFO drops the sample even if the output register pops this cycle
    assign push       = bus.s_en && !fifo_full;
    assign beat       = do_en_r && bus.do_ready;
    assign last_beat  = beat && do_last_r;
    assign head       = mem[rd_ptr];

    // Decide whether the current state lets the output register take a new sample.
    // With a gap configured, the frame's last beat must not pull the next frame's first
    // sample in behind it; the final gap cycle hands over directly so the idle window
    // on do_en is exactly GAP_CYCLES long.
    always_comb begin
        load_ok = 1'b0;
        case (state)
            IDLE:    load_ok = 1'b1;
            SEND:    load_ok = !(HAS_GAP && last_beat);
            GAP:     load_ok = (gap_cnt == GAP_END);
            default: load_ok = 1'b0;
        endcase
    end

    assign load = load_ok && !fifo_empty && (!do_en_r || beat);

    // Write side of the FIFO storage array; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.s_data;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(load);
            if (bus.s_en && fifo_full) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Framing FSM with the registered output stage, sample index and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            idx         <= '0;
            do_en_r     <= 1'b0;
            do_last_r   <= 1'b0;
            dout_r      <= '0;
            frame_cnt_r <= '0;
        end else begin
            if (load) begin
                dout_r    <= head;
                do_en_r   <= 1'b1;
                do_last_r <= (idx == IDX_LAST);
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else if (beat) begin
                do_en_r <= 1'b0;
            end

            if (last_beat) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (last_beat) begin
                        if (HAS_GAP) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else if (fifo_empty) begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_END) begin
                        state <= fifo_empty ? IDLE : SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.do_en     = do_en_r;
    assign bus.do_last   = do_last_r;
    assign bus.dout      = dout_r;
    assign bus.frame_cnt = frame_cnt_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_fft_frame_source.sv
// tb/tb_fft_frame_source.sv - directed self-checking bench for fft_frame_source
module tb_fft_frame_source;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    fft_frame_source_if #(.DATA_W(32)) ifa ();
    fft_frame_source_if #(.DATA_W(32)) ifb ();
    fft_frame_source_if #(.DATA_W(32)) ifc ();

    fft_frame_source #(.FRAME_LEN(8), .DATA_W(32), .FIFO_DEPTH(16), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    fft_frame_source #(.FRAME_LEN(8), .DATA_W(32), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );
    fft_frame_source #(.FRAME_LEN(4), .DATA_W(32), .FIFO_DEPTH(16), .GAP_CYCLES(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s_en;
        logic [31:0] s_data;
        logic        ready;
        logic        exp_en;
        logic        exp_last;
        logic [31:0] exp_dout;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic se, logic [31:0] sd, logic rdy,
                                logic en, logic lst, logic [31:0] d, logic [15:0] fc);
        vec_t v;
        v.s_en = se; v.s_data = sd; v.ready = rdy;
        v.exp_en = en; v.exp_last = lst; v.exp_dout = d; v.exp_fc = fc;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " a do_en"},     32'(ifa.do_en),     32'd0);
        check({tag, " a do_last"},   32'(ifa.do_last),   32'd0);
        check({tag, " a dout"},      ifa.dout,           32'd0);
        check({tag, " a frame_cnt"}, 32'(ifa.frame_cnt), 32'd0);
        check({tag, " a overflow"},  32'(ifa.overflow),  32'd0);
        check({tag, " b do_en"},     32'(ifb.do_en),     32'd0);
        check({tag, " b overflow"},  32'(ifb.overflow),  32'd0);
        check({tag, " c do_en"},     32'(ifc.do_en),     32'd0);
        check({tag, " c frame_cnt"}, 32'(ifc.frame_cnt), 32'd0);
    endtask

    logic        en_tr   [40];
    logic        last_tr [40];
    logic [31:0] d_tr    [40];
    logic [15:0] fc_tr   [40];
    logic [31:0] got[$];

    initial begin
        int expv;
        int lasts;
        int gap;
        int k;
        int nbeats;

        checks = 0;
        errors = 0;

        // Basic frame on dut_a: samples 1..8, ready held high
        tbl.push_back(mk(1, 32'h1, 1, 0, 0, 32'h0, 16'd0));
        tbl.push_back(mk(1, 32'h2, 1, 1, 0, 32'h1, 16'd0));
        tbl.push_back(mk(1, 32'h3, 1, 1, 0, 32'h2, 16'd0));
        tbl.push_back(mk(1, 32'h4, 1, 1, 0, 32'h3, 16'd0));
        tbl.push_back(mk(1, 32'h5, 1, 1, 0, 32'h4, 16'd0));
        tbl.push_back(mk(1, 32'h6, 1, 1, 0, 32'h5, 16'd0));
        tbl.push_back(mk(1, 32'h7, 1, 1, 0, 32'h6, 16'd0));
        tbl.push_back(mk(1, 32'h8, 1, 1, 0, 32'h7, 16'd0));
        tbl.push_back(mk(0, 32'h0, 1, 1, 1, 32'h8, 16'd0));
        tbl.push_back(mk(0, 32'h0, 1, 0, 0, 32'h0, 16'd1));
        // Backpressure on dut_a: ready low for 5 edges while 0x3 is presented
        tbl.push_back(mk(1, 32'h1, 1, 0, 0, 32'h0, 16'd1));
        tbl.push_back(mk(1, 32'h2, 1, 1, 0, 32'h1, 16'd1));
        tbl.push_back(mk(1, 32'h3, 1, 1, 0, 32'h2, 16'd1));
        tbl.push_back(mk(1, 32'h4, 1, 1, 0, 32'h3, 16'd1));
        tbl.push_back(mk(1, 32'h5, 0, 1, 0, 32'h3, 16'd1));
        tbl.push_back(mk(1, 32'h6, 0, 1, 0, 32'h3, 16'd1));
        tbl.push_back(mk(1, 32'h7, 0, 1, 0, 32'h3, 16'd1));
        tbl.push_back(mk(1, 32'h8, 0, 1, 0, 32'h3, 16'd1));
        tbl.push_back(mk(0, 32'h0, 0, 1, 0, 32'h3, 16'd1));
        tbl.push_back(mk(0, 32'h0, 1, 1, 0, 32'h4, 16'd1));
        tbl.push_back(mk(0, 32'h0, 1, 1, 0, 32'h5, 16'd1));
        tbl.push_back(mk(0, 32'h0, 1, 1, 0, 32'h6, 16'd1));
        tbl.push_back(mk(0, 32'h0, 1, 1, 0, 32'h7, 16'd1));
        tbl.push_back(mk(0, 32'h0, 1, 1, 1, 32'h8, 16'd1));
        tbl.push_back(mk(0, 32'h0, 1, 0, 0, 32'h0, 16'd2));

        // Reset with random input activity on every instance
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifa.s_en = 1'($urandom_range(0, 1)); ifa.s_data = $urandom; ifa.do_ready = 1'($urandom_range(0, 1));
            ifb.s_en = 1'($urandom_range(0, 1)); ifb.s_data = $urandom; ifb.do_ready = 1'($urandom_range(0, 1));
            ifc.s_en = 1'($urandom_range(0, 1)); ifc.s_data = $urandom; ifc.do_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check_reset_values("reset");
        ifa.s_en = 0; ifa.s_data = 0; ifa.do_ready = 0;
        ifb.s_en = 0; ifb.s_data = 0; ifb.do_ready = 0;
        ifc.s_en = 0; ifc.s_data = 0; ifc.do_ready = 0;
        rst_n = 1'b1;
        tick();

        // Table-driven basic frame and backpressure
        for (int i = 0; i < tbl.size(); i++) begin
            ifa.s_en     = tbl[i].s_en;
            ifa.s_data   = tbl[i].s_data;
            ifa.do_ready = tbl[i].ready;
            tick();
            check($sformatf("vec%0d do_en", i), 32'(ifa.do_en), 32'(tbl[i].exp_en));
            if (tbl[i].exp_en) begin
                check($sformatf("vec%0d dout", i), ifa.dout, tbl[i].exp_dout);
                check($sformatf("vec%0d do_last", i), 32'(ifa.do_last), 32'(tbl[i].exp_last));
            end
            check($sformatf("vec%0d frame_cnt", i), 32'(ifa.frame_cnt), 32'(tbl[i].exp_fc));
            check($sformatf("vec%0d overflow", i), 32'(ifa.overflow), 32'd0);
        end

        // Overflow on dut_b (depth 4): 0xA0..0xA5 with ready low, 0xA5 is dropped
        ifb.do_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ifb.s_en   = 1'b1;
            ifb.s_data = 32'hA0 + 32'(i);
            tick();
            if (i == 4) check("ovf before drop", 32'(ifb.overflow), 32'd0);
        end
        check("ovf after 6th edge", 32'(ifb.overflow), 32'd1);
        ifb.s_en = 1'b0;
        ifb.do_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (ifb.do_en) got.push_back(ifb.dout);
            tick();
        end
        check("ovf beat count", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size() && i < 5; i++) begin
            check($sformatf("ovf beat%0d", i), got[i], 32'hA0 + 32'(i));
        end
        check("ovf sticky", 32'(ifb.overflow), 32'd1);
        check("ovf no frame", 32'(ifb.frame_cnt), 32'd0);

        // Gap on dut_c (FRAME_LEN 4, GAP 3): 12 samples, continuous input
        ifc.do_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            ifc.s_en   = (c < 12);
            ifc.s_data = 32'(c + 1);
            tick();
            en_tr[c] = ifc.do_en; last_tr[c] = ifc.do_last;
            d_tr[c] = ifc.dout;   fc_tr[c] = ifc.frame_cnt;
        end
        ifc.s_en = 1'b0;
        expv = 1;
        lasts = 0;
        for (int c = 0; c < 40; c++) begin
            if (en_tr[c]) begin
                check($sformatf("gap dout%0d", expv), d_tr[c], 32'(expv));
                check($sformatf("gap last%0d", expv), 32'(last_tr[c]), 32'((expv % 4) == 0));
                if (last_tr[c]) begin
                    lasts++;
                    if (c + 1 < 40) check($sformatf("gap frame_cnt%0d", lasts), 32'(fc_tr[c+1]), 32'(lasts));
                    if (lasts < 3) begin
                        gap = 0;
                        k = c + 1;
                        while (k < 40 && !en_tr[k]) begin
                            gap++;
                            k++;
                        end
                        check($sformatf("gap len%0d", lasts), 32'(gap), 32'd3);
                    end
                end
                expv++;
            end
        end
        check("gap beats", 32'(expv - 1), 32'd12);

        // Reset in the middle of a frame on dut_a
        ifa.do_ready = 1'b1;
        nbeats = 0;
        for (int i = 0; i < 7; i++) begin
            if (ifa.do_en) nbeats++;
            ifa.s_en   = 1'b1;
            ifa.s_data = 32'h11 + 32'(i);
            tick();
        end
        check("midrst beats before", 32'(nbeats), 32'd5);
        ifa.s_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        nbeats = 0;
        for (int c = 0; c < 20; c++) begin
            if (ifa.do_en) begin
                check($sformatf("midrst dout%0d", nbeats), ifa.dout, 32'h21 + 32'(nbeats));
                check($sformatf("midrst last%0d", nbeats), 32'(ifa.do_last), 32'(nbeats == 7));
                nbeats++;
            end
            ifa.s_en   = (c < 8);
            ifa.s_data = 32'h21 + 32'(c);
            tick();
        end
        check("midrst beats after", 32'(nbeats), 32'd8);
        check("midrst frame_cnt", 32'(ifa.frame_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
